// File: rtl/instr_fetch_unit.sv
// Purpose : PC register plus a small prefetch queue in front of decode.
// Latency : 1 cycle from memory return to valid_o; redirect shows the target
//           on pc_addr_o next cycle and as valid_o the cycle after that.
// Backpressure: ready_i=0 fills the queue; once full, fetch stalls and the PC holds.
//
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   fetch_en_i        fetch allowed this cycle
//   pc_addr_o         word-aligned byte address to instruction memory (= PC)
//   instr_i           combinational memory return for pc_addr_o
//   redirect_i/_pc_i  branch/jump redirect and its target byte address
//   instr_o/instr_pc_o/valid_o/ready_i  head of the queue towards decode
//   level_o           queue occupancy 0..QUEUE_DEPTH
//   misalign_o        sticky misaligned-redirect flag
//
// Build option: FETCH_ALIGN_CHK_EN
//   undefined : redirect target low bits are dropped, misalign_o is 0.
//   defined   : a misaligned redirect flushes, keeps the old PC, raises
//               misalign_o and blocks fetch and further redirects until reset.

// Purpose : generic synchronous FIFO with flush; empty head reads as zero.
// Latency : 1 cycle push to pop_vld.
// Backpressure: caller must not push when full unless popping in the same cycle.
module ifu_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic [LW-1:0] level,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [LW-1:0] count_q;
  logic          do_pop;

  assign pop_vld = (count_q != '0);
  assign full    = (count_q == LW'(DEPTH));
  assign level   = count_q;
  assign do_pop  = pop_vld & pop_rdy;

  // Entries left behind by pops or a flush are stale, so gate the head.
  assign pop_dat = pop_vld ? mem_q[head_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_vld) begin
        mem_q[tail_q] <= push_dat;
        tail_q        <= tail_q + PW'(1);
      end
      if (do_pop) begin
        head_q <= head_q + PW'(1);
      end
      case ({push_vld, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  level_o,
  output logic        misalign_o
);

  localparam int LW = $clog2(QUEUE_DEPTH + 1);

  // Only the word index is stored, so the address is aligned by construction
  // and +4 wraps mod 2^32 naturally.
  logic [29:0]   pc_q;
  logic          pop;
  logic          push;
  logic          redir_take;
  logic          redir_bad;
  logic          misalign_q;
  logic          fifo_full;
  logic [LW-1:0] fifo_level;
  logic [63:0]   head_dat;

  assign pc_addr_o = {pc_q, 2'b00};
  assign pop       = valid_o & ready_i;

`ifdef FETCH_ALIGN_CHK_EN
  // Once the flag is up, redirects are ignored until reset.
  assign redir_take = redirect_i & ~misalign_q;
  assign redir_bad  = redir_take & (redirect_pc_i[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (redir_bad) begin
      misalign_q <= 1'b1;
    end
  end
`else
  logic unused_redirect_lsb;

  assign redir_take          = redirect_i;
  assign redir_bad           = 1'b0;
  assign misalign_q          = 1'b0;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
`endif

  assign misalign_o = misalign_q;

  // A full queue still accepts a fetch when the head leaves this cycle.
  assign push = fetch_en_i & ~redirect_i & ~misalign_q & (~fifo_full | pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC[31:2];
    end else if (redir_take) begin
      if (!redir_bad) begin
        pc_q <= redirect_pc_i[31:2];
      end
    end else if (push) begin
      pc_q <= pc_q + 30'd1;
    end
  end

  // Redirect flushes the queue; a pop in the same cycle is simply lost.
  ifu_fifo #(
    .W     (64),
    .DEPTH (QUEUE_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .flush    (redir_take),
    .push_vld (push),
    .push_dat ({pc_addr_o, instr_i}),
    .pop_rdy  (ready_i),
    .pop_vld  (valid_o),
    .pop_dat  (head_dat),
    .level    (fifo_level),
    .full     (fifo_full)
  );

  assign instr_pc_o = head_dat[63:32];
  assign instr_o    = head_dat[31:0];
  assign level_o    = 4'(fifo_level);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 2;
  localparam int          NCYC   = 3000;
`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk_i;
  logic        rst_i;
  logic        fetch_en_i;
  logic [31:0] pc_addr_o;
  logic [31:0] instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  level_o;
  logic        misalign_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Memory: word k holds k.
  assign instr_i = pc_addr_o >> 2;

  instr_fetch_unit #(
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fetch_en_i    (fetch_en_i),
    .pc_addr_o     (pc_addr_o),
    .instr_i       (instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .level_o       (level_o),
    .misalign_o    (misalign_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc, instr} pairs plus the PC.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_mis;

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    if (rst_i) begin
      q.delete();
      m_pc  = RST_PC;
      m_mis = 1'b0;
    end else begin
      do_pop = (q.size() > 0) && ready_i;
      if (redirect_i && !m_mis) begin
        q.delete();
        if (ALIGN && redirect_pc_i[1:0] != 2'b00) m_mis = 1'b1;
        else m_pc = redirect_pc_i & 32'hFFFF_FFFC;
      end else begin
        do_push = fetch_en_i && !redirect_i && !m_mis && ((q.size() < DEPTH) || do_pop);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          e.pc  = m_pc;
          e.ins = m_pc >> 2;
          q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    exp_pc  = (q.size() > 0) ? q[0].pc  : 32'h0;
    exp_ins = (q.size() > 0) ? q[0].ins : 32'h0;
    check("level",    32'(level_o),    32'(q.size()));
    check("valid",    32'(valid_o),    32'(q.size() != 0));
    check("head_pc",  instr_pc_o,      exp_pc);
    check("head_ins", instr_o,         exp_ins);
    check("pc_addr",  pc_addr_o,       m_pc);
    check("misalign", 32'(misalign_o), 32'(m_mis));
  endtask

  task automatic drive(input int c);
    rst_i         = 1'b0;
    fetch_en_i    = 1'b1;
    ready_i       = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    if (c < 2) begin
      rst_i = 1'b1;
    end else if (c < 20) begin
      // free run through the PC wrap after reset
    end else if (c < 25) begin
      ready_i = 1'b0;
    end else if (c < 30) begin
      // resume draining
    end else if (c == 30) begin
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h40;
    end else if (c < 35) begin
      // run from the redirect target
    end else if (c == 35) begin
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h42;
    end else if (c < 40) begin
      ready_i = 1'b0;
    end else if (c == 40) begin
      rst_i = 1'b1;
    end else begin
      rst_i      = ($urandom_range(0, 99) < 2);
      fetch_en_i = ($urandom_range(0, 99) < 85);
      ready_i    = ($urandom_range(0, 99) < 65);
      redirect_i = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0:       redirect_pc_i = $urandom & 32'h0000_0FFF;
        1:       redirect_pc_i = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        2:       redirect_pc_i = $urandom;
        default: redirect_pc_i = $urandom & 32'h0000_00FC;
      endcase
    end
  endtask

  initial begin
    rst_i         = 1'b1;
    fetch_en_i    = 1'b0;
    ready_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    model_step();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk_i);
      check_outputs();
      drive(c);
      model_step();
    end
    @(negedge clk_i);
    check_outputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
